csr_hpm_counters: RTL and testbench
===================================

// Module: csr_hpm_counters
// PURPOSE
//   Machine-mode counter unit: mcycle, minstret and NUM_HPM programmable
//   hardware performance counters (mhpmcounter3..), with per-counter event
//   select, mcountinhibit, overflow status and an overflow interrupt.
//   Sits beside the CSR file in write-back. Counter CSR reads and writes
//   are routed here. Its interrupt feeds the interrupt-enable logic.
// PARAMETERS
//   NUM_HPM  4   number of mhpmcounterN/mhpmeventN pairs, 1..29 (N = 3..NUM_HPM+2)
//   CNT_W    64  implemented counter width, 33..64; bits >= CNT_W read 0, writes ignored
//   NUM_EVT  8   number of event inputs, 1..255
// PORTS
//   clk           in   1        core clock
//   cpurst_n      in   1        asynchronous active-low reset
//   inst_retire   in   1        one instruction retired this cycle
//   evt_in        in   NUM_EVT  event strobes, one count per asserted cycle
//   csr_wr_en     in   1        CSR write strobe (write-back stage)
//   csr_wr_index  in   12       CSR write address
//   csr_wr_wdata  in   32       CSR write data (final value, after set/clear op)
//   csr_r_index   in   12       CSR read address
//   csr_rdat      out  32       read data, combinational from current state
//   csr_hit       out  1        csr_r_index decodes to a register in this block
//   ovf_irq       out  1        registered overflow interrupt request
// BEHAVIOUR
// - One clock; reset is asynchronous and active-low (clk, cpurst_n).
//   Reset clears all counters, mhpmevent, mcountinhibit, ovf_status,
//   ovf_en and ovf_irq.
// - Counter index i: 0 = mcycle, 2 = minstret, 3..NUM_HPM+2 = hpm.
//   Address map:
//     low word b00 + i, high word b80 + i
//     mhpmevent i at 320 + i (i >= 3)
//     mcountinhibit at 320
//     ovf_status at 7C0, ovf_en at 7C1
// - mcountinhibit bit i gates counter i. Bit 1 and bits above NUM_HPM+2
//   are hardwired 0.
// - Increment conditions, each counter by 1 per cycle when not inhibited:
//     mcycle: every cycle
//     minstret: when inst_retire
//     hpm: when evt_in[sel-1], sel = mhpmevent[7:0] in 1..NUM_EVT
//       sel = 0 or sel > NUM_EVT never counts
//       mhpmevent bits [31:8] read 0
// - Writes take effect at the next clock edge.
//   - A write to a counter word replaces that word. The same-cycle
//     increment of that counter is dropped: the written value wins, and
//     the other word is unchanged.
//   - Reads return the updated value from the following cycle.
// - Wrap: counter all-ones (CNT_W bits) plus increment -> 0. Set
//   ovf_status bit i on the same edge. No carry is beyond CNT_W.
// - ovf_status:
//   - Written data is W1C: a 1 clears the bit.
//   - A set and a clear on the same edge: the set wins.
//   - Sets nothing on a CSR write that forces a wrap value.
// - ovf_en is plain R/W with the same bit layout as mcountinhibit.
// - ovf_irq <= |(ovf_status & ovf_en), registered, so it rises one cycle
//   after the status bit sets. It stays high until cleared or masked.
// - csr_hit = 0 and csr_rdat = 0 for unmapped addresses, and for hpm
//   addresses of i > NUM_HPM+2.
// - Reset asserted mid-count: all state is zero immediately
//   (asynchronous). Counting resumes on the first edge after deassertion.
// TESTING
// - Reset release, no writes, 10 cycles: mcycle low = 10 (counted from
//   the first edge after deassertion), minstret = 0, all hpm = 0,
//   ovf_irq = 0.
// - mhpmevent3 = 2; pulse evt_in[1] for 5 cycles and evt_in[0] for 3:
//   mhpmcounter3 = 5. Set sel = 0 -> the counter freezes.
// - Write mhpmcounter3 low = FFFF_FFFE, high = FFFF_FFFF, ovf_en bit3 = 1,
//   event constant:
//   - After 2 counts the counter = 0 and ovf_status = 0x8.
//   - ovf_irq is high one cycle later.
//   - W1C 0x8 -> ovf_irq drops the next cycle.
// - inst_retire high every cycle, then write minstret low = 0x100 in
//   cycle t: read at t+1 = 0x100, at t+2 = 0x101 (increment at t dropped).
// - mcountinhibit = 0x5: mcycle and minstret hold for 20 cycles.
//   Clear it -> both resume. Bit 1 reads back 0 after writing FFFF_FFFF.
// - CNT_W = 40: write mcycleh = FFFF_FFFF -> reads 0000_00FF. Read 0xB83
//   with NUM_HPM = 0..: csr_hit = 0 beyond the last counter.

Source files
------------

// File: rtl/csr_hpm_counters.sv
// Machine-mode counter unit: mcycle, minstret and NUM_HPM event counters with
// mcountinhibit, overflow status/enable and a registered overflow interrupt.
module csr_hpm_counters #(
    parameter int unsigned NUM_HPM = 4,
    parameter int unsigned CNT_W   = 64,
    parameter int unsigned NUM_EVT = 8
) (
    input  logic               clk,
    input  logic               cpurst_n,
    input  logic               inst_retire,
    input  logic [NUM_EVT-1:0] evt_in,
    input  logic               csr_wr_en,
    input  logic [11:0]        csr_wr_index,
    input  logic [31:0]        csr_wr_wdata,
    input  logic [11:0]        csr_r_index,
    output logic [31:0]        csr_rdat,
    output logic               csr_hit,
    output logic               ovf_irq
);
    localparam int unsigned NCNT = NUM_HPM + 3;
    localparam int unsigned HI_W = CNT_W - 32;
    // Bit 1 (time) is not a counter here and stays zero in every per-counter mask.
    localparam logic [NCNT-1:0] CNT_MASK = ~(NCNT'(2));

    function automatic logic cnt_valid(input logic [4:0] idx);
        return (idx == 5'd0) || ((idx >= 5'd2) && (32'(idx) < NCNT));
    endfunction

    function automatic logic evt_valid(input logic [4:0] idx);
        return (idx >= 5'd3) && (32'(idx) < NCNT);
    endfunction

    logic [CNT_W-1:0] cnt_q     [NCNT];
    logic [7:0]       evt_sel_q [NCNT];
    logic [NCNT-1:0]  inh_q;
    logic [NCNT-1:0]  ovf_q;
    logic [NCNT-1:0]  ovf_en_q;

    logic [4:0]      wr_idx;
    logic [4:0]      rd_idx;
    logic            wr_lo, wr_hi, wr_evt, wr_inh, wr_ovs, wr_ove;
    logic [NCNT-1:0] inc;
    logic [NCNT-1:0] cnt_wr;
    logic [NCNT-1:0] ovf_set;

    assign wr_idx = csr_wr_index[4:0];
    assign rd_idx = csr_r_index[4:0];

    // Write address decode
    always_comb begin
        wr_lo  = csr_wr_en && (csr_wr_index[11:5] == 7'h58) && cnt_valid(wr_idx);
        wr_hi  = csr_wr_en && (csr_wr_index[11:5] == 7'h5C) && cnt_valid(wr_idx);
        wr_evt = csr_wr_en && (csr_wr_index[11:5] == 7'h19) && evt_valid(wr_idx);
        wr_inh = csr_wr_en && (csr_wr_index == 12'h320);
        wr_ovs = csr_wr_en && (csr_wr_index == 12'h7C0);
        wr_ove = csr_wr_en && (csr_wr_index == 12'h7C1);
    end

    // Per-counter increment; a CSR write to a counter suppresses its increment and wrap flag
    always_comb begin
        inc     = '0;
        cnt_wr  = '0;
        ovf_set = '0;
        for (int i = 0; i < NCNT; i++) begin
            cnt_wr[i] = (wr_lo || wr_hi) && (wr_idx == 5'(i));
            if (i == 0) begin
                inc[i] = 1'b1;
            end else if (i == 2) begin
                inc[i] = inst_retire;
            end else if (i >= 3) begin
                for (int e = 0; e < NUM_EVT; e++) begin
                    if ((evt_sel_q[i] == 8'(e + 1)) && evt_in[e]) begin
                        inc[i] = 1'b1;
                    end
                end
            end
            inc[i]     = inc[i] & ~inh_q[i];
            ovf_set[i] = inc[i] && !cnt_wr[i] && (&cnt_q[i]);
        end
    end

    always_ff @(posedge clk or negedge cpurst_n) begin
        if (!cpurst_n) begin
            for (int i = 0; i < NCNT; i++) begin
                cnt_q[i]     <= '0;
                evt_sel_q[i] <= '0;
            end
            inh_q    <= '0;
            ovf_q    <= '0;
            ovf_en_q <= '0;
            ovf_irq  <= 1'b0;
        end else begin
            for (int i = 0; i < NCNT; i++) begin
                if (cnt_wr[i]) begin
                    if (wr_lo) begin
                        cnt_q[i][31:0] <= csr_wr_wdata;
                    end else begin
                        cnt_q[i][CNT_W-1:32] <= csr_wr_wdata[HI_W-1:0];
                    end
                end else if (inc[i]) begin
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                end
                if (wr_evt && (wr_idx == 5'(i))) begin
                    evt_sel_q[i] <= csr_wr_wdata[7:0];
                end
            end
            if (wr_inh) begin
                inh_q <= csr_wr_wdata[NCNT-1:0] & CNT_MASK;
            end
            if (wr_ove) begin
                ovf_en_q <= csr_wr_wdata[NCNT-1:0] & CNT_MASK;
            end
            ovf_q   <= (ovf_q & ~(wr_ovs ? csr_wr_wdata[NCNT-1:0] : '0)) | ovf_set;
            ovf_irq <= |(ovf_q & ovf_en_q);
        end
    end

    // Combinational read mux
    logic [63:0] rd_cnt;
    logic [7:0]  rd_sel;

    always_comb begin
        rd_cnt   = '0;
        rd_sel   = '0;
        csr_rdat = '0;
        csr_hit  = 1'b0;
        for (int i = 0; i < NCNT; i++) begin
            if (rd_idx == 5'(i)) begin
                rd_cnt = 64'(cnt_q[i]);
                rd_sel = evt_sel_q[i];
            end
        end
        if ((csr_r_index[11:5] == 7'h58) && cnt_valid(rd_idx)) begin
            csr_hit  = 1'b1;
            csr_rdat = rd_cnt[31:0];
        end else if ((csr_r_index[11:5] == 7'h5C) && cnt_valid(rd_idx)) begin
            csr_hit  = 1'b1;
            csr_rdat = rd_cnt[63:32];
        end else if ((csr_r_index[11:5] == 7'h19) && evt_valid(rd_idx)) begin
            csr_hit  = 1'b1;
            csr_rdat = {24'd0, rd_sel};
        end else if (csr_r_index == 12'h320) begin
            csr_hit  = 1'b1;
            csr_rdat = 32'(inh_q);
        end else if (csr_r_index == 12'h7C0) begin
            csr_hit  = 1'b1;
            csr_rdat = 32'(ovf_q);
        end else if (csr_r_index == 12'h7C1) begin
            csr_hit  = 1'b1;
            csr_rdat = 32'(ovf_en_q);
        end
    end

endmodule

// File: tb/tb_csr_hpm_counters.sv
// Self-checking bench for csr_hpm_counters: directed scenarios plus randomized
// traffic compared against a cycle-level behavioural model.
module tb_csr_hpm_counters;
    localparam int unsigned NUM_HPM = 4;
    localparam int unsigned CNT_W   = 40;
    localparam int unsigned NUM_EVT = 8;
    localparam int unsigned NCNT    = NUM_HPM + 3;
    localparam logic [63:0] MAXV    = (64'd1 << CNT_W) - 64'd1;
    localparam logic [6:0]  LAYOUT  = 7'b1111101;
    localparam logic [11:0] ADDRS [24] = '{
        12'hB00, 12'hB02, 12'hB03, 12'hB04, 12'hB05, 12'hB06,
        12'hB80, 12'hB82, 12'hB83, 12'hB84, 12'hB85, 12'hB86,
        12'h320, 12'h323, 12'h324, 12'h325, 12'h326,
        12'h7C0, 12'h7C1, 12'hB01, 12'hB87, 12'h327, 12'h7C2, 12'hB81};

    logic        clk = 1'b0;
    logic        cpurst_n = 1'b0;
    logic        inst_retire = 1'b0;
    logic [7:0]  evt_in = '0;
    logic        csr_wr_en = 1'b0;
    logic [11:0] csr_wr_index = '0;
    logic [31:0] csr_wr_wdata = '0;
    logic [11:0] csr_r_index = '0;
    logic [31:0] csr_rdat;
    logic        csr_hit;
    logic        ovf_irq;

    int checks = 0;
    int failures = 0;

    // Reference state
    bit [63:0] m_cnt [NCNT];
    bit [7:0]  m_sel [NCNT];
    bit [6:0]  m_inh, m_ovs, m_ove;
    bit        m_irq;

    csr_hpm_counters #(.NUM_HPM(NUM_HPM), .CNT_W(CNT_W), .NUM_EVT(NUM_EVT)) dut (
        .clk(clk), .cpurst_n(cpurst_n), .inst_retire(inst_retire), .evt_in(evt_in),
        .csr_wr_en(csr_wr_en), .csr_wr_index(csr_wr_index), .csr_wr_wdata(csr_wr_wdata),
        .csr_r_index(csr_r_index), .csr_rdat(csr_rdat), .csr_hit(csr_hit), .ovf_irq(ovf_irq));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCNT; i++) begin
            m_cnt[i] = '0;
            m_sel[i] = '0;
        end
        m_inh = '0; m_ovs = '0; m_ove = '0; m_irq = 1'b0;
    endtask

    function automatic logic [32:0] m_read(input logic [11:0] a);
        if (a == 12'h320) return {1'b1, 25'd0, m_inh};
        if (a == 12'h7C0) return {1'b1, 25'd0, m_ovs};
        if (a == 12'h7C1) return {1'b1, 25'd0, m_ove};
        for (int i = 3; i < NCNT; i++)
            if (a == 12'h320 + 12'(i)) return {1'b1, 24'd0, m_sel[i]};
        for (int i = 0; i < NCNT; i++) begin
            if (i != 1) begin
                if (a == 12'hB00 + 12'(i)) return {1'b1, m_cnt[i][31:0]};
                if (a == 12'hB80 + 12'(i)) return {1'b1, m_cnt[i][63:32]};
            end
        end
        return 33'd0;
    endfunction

    // One clock of the architectural rules, using the inputs driven for that cycle
    task automatic model_step();
        bit [6:0] set_b = '0;
        bit [6:0] clr_b = '0;
        bit       nirq;
        bit       en;
        nirq = |(m_ovs & m_ove);
        for (int i = 0; i < NCNT; i++) begin
            if (i == 1) continue;
            if (i == 0) en = 1'b1;
            else if (i == 2) en = inst_retire;
            else en = (m_sel[i] >= 8'd1) && (m_sel[i] <= 8'(NUM_EVT)) && evt_in[m_sel[i] - 8'd1];
            if (m_inh[i]) en = 1'b0;
            if (csr_wr_en && csr_wr_index == 12'hB00 + 12'(i))
                m_cnt[i] = {m_cnt[i][63:32], csr_wr_wdata} & MAXV;
            else if (csr_wr_en && csr_wr_index == 12'hB80 + 12'(i))
                m_cnt[i] = {csr_wr_wdata, m_cnt[i][31:0]} & MAXV;
            else if (en) begin
                if (m_cnt[i] == MAXV) begin
                    m_cnt[i] = '0;
                    set_b[i] = 1'b1;
                end else begin
                    m_cnt[i] = m_cnt[i] + 64'd1;
                end
            end
        end
        if (csr_wr_en) begin
            if (csr_wr_index == 12'h320) m_inh = csr_wr_wdata[6:0] & LAYOUT;
            if (csr_wr_index == 12'h7C0) clr_b = csr_wr_wdata[6:0];
            if (csr_wr_index == 12'h7C1) m_ove = csr_wr_wdata[6:0] & LAYOUT;
            for (int i = 3; i < NCNT; i++)
                if (csr_wr_index == 12'h320 + 12'(i)) m_sel[i] = csr_wr_wdata[7:0];
        end
        m_ovs = (m_ovs & ~clr_b) | set_b;
        m_irq = nirq;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        csr_wr_en = 1'b1; csr_wr_index = a; csr_wr_wdata = d;
        tick();
        csr_wr_en = 1'b0;
    endtask

    task automatic check_rd(input string tag, input logic [11:0] a);
        logic [32:0] r;
        csr_r_index = a;
        #1;
        r = m_read(a);
        check({tag, "_hit"}, 64'(csr_hit), 64'(r[32]));
        check(tag, 64'(csr_rdat), 64'(r[31:0]));
    endtask

    task automatic check_const(input string tag, input logic [11:0] a, input logic [31:0] exp);
        csr_r_index = a;
        #1;
        check(tag, 64'(csr_rdat), 64'(exp));
    endtask

    bit [63:0] saved0, saved2;

    initial begin
        model_reset();
        #12;
        @(posedge clk); #1;
        cpurst_n = 1'b1;
        check_const("rst_mcycle", 12'hB00, 32'd0);
        check("rst_irq", 64'(ovf_irq), 64'd0);

        // Ten cycles after release
        repeat (10) tick();
        check_const("mcycle10", 12'hB00, 32'd10);
        check_const("minstret0", 12'hB02, 32'd0);
        for (int i = 3; i < NCNT; i++) check_rd("hpm0", 12'hB00 + 12'(i));
        check("irq0", 64'(ovf_irq), 64'd0);

        // Event select 2 counts only evt_in[1]
        wr(12'h323, 32'd2);
        evt_in = 8'h02; repeat (5) tick();
        evt_in = 8'h01; repeat (3) tick();
        evt_in = 8'h00;
        check_const("hpm3_sel2", 12'hB03, 32'd5);
        wr(12'h323, 32'd0);
        evt_in = 8'hFF; repeat (4) tick();
        evt_in = 8'h00;
        check_const("hpm3_frozen", 12'hB03, 32'd5);

        // Wrap, overflow status, interrupt and W1C
        wr(12'hB03, 32'hFFFF_FFFE);
        wr(12'hB83, 32'hFFFF_FFFF);
        check_const("hpm3h_trunc", 12'hB83, 32'h0000_00FF);
        wr(12'h7C1, 32'h8);
        wr(12'h323, 32'd1);
        evt_in = 8'h01; tick(); tick();
        evt_in = 8'h00;
        check_const("wrap_cnt", 12'hB03, 32'd0);
        check_const("wrap_status", 12'h7C0, 32'h8);
        check("irq_not_yet", 64'(ovf_irq), 64'd0);
        tick();
        check("irq_high", 64'(ovf_irq), 64'd1);
        wr(12'h7C0, 32'h8);
        check_const("w1c_status", 12'h7C0, 32'h0);
        check("irq_lag", 64'(ovf_irq), 64'(m_irq));
        tick();
        check("irq_dropped", 64'(ovf_irq), 64'd0);

        // Write to minstret drops that cycle's increment
        inst_retire = 1'b1;
        repeat (3) tick();
        wr(12'hB02, 32'h100);
        check_const("minstret_wr", 12'hB02, 32'h100);
        tick();
        check_const("minstret_inc", 12'hB02, 32'h101);

        // mcountinhibit holds mcycle and minstret
        wr(12'h320, 32'h5);
        saved0 = m_cnt[0]; saved2 = m_cnt[2];
        repeat (20) tick();
        check_const("inh_mcycle", 12'hB00, saved0[31:0]);
        check_const("inh_minstret", 12'hB02, saved2[31:0]);
        wr(12'h320, 32'h0);
        repeat (3) tick();
        check_rd("resume_mcycle", 12'hB00);
        check_rd("resume_minstret", 12'hB02);
        wr(12'h320, 32'hFFFF_FFFF);
        check_const("inh_layout", 12'h320, 32'h0000_007D);
        wr(12'h320, 32'h0);
        inst_retire = 1'b0;

        // Width and decode boundaries
        wr(12'hB80, 32'hFFFF_FFFF);
        check_const("mcycleh_trunc", 12'hB80, 32'h0000_00FF);
        check_rd("last_hpm", 12'hB86);
        check_rd("beyond_hpm", 12'hB87);
        check_rd("time_unmapped", 12'hB01);
        csr_r_index = 12'h7C2; #1;
        check("unmapped_hit", 64'(csr_hit), 64'd0);
        check("unmapped_data", 64'(csr_rdat), 64'd0);

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            inst_retire = 1'($urandom);
            evt_in = 8'($urandom);
            csr_wr_en = ($urandom_range(0, 3) == 0);
            csr_wr_index = ADDRS[$urandom_range(0, 23)];
            case ($urandom_range(0, 3))
                0: csr_wr_wdata = $urandom;
                1: csr_wr_wdata = 32'hFFFF_FFFF;
                2: csr_wr_wdata = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
                default: csr_wr_wdata = 32'($urandom_range(0, 10));
            endcase
            tick();
            csr_wr_en = 1'b0;
            check("rnd_irq", 64'(ovf_irq), 64'(m_irq));
            check_rd("rnd_rd", ADDRS[$urandom_range(0, 23)]);
        end
        inst_retire = 1'b0; evt_in = '0;

        // Asynchronous reset in the middle of counting
        #1 cpurst_n = 1'b0;
        #1 model_reset();
        check_const("midrst_mcycle", 12'hB00, 32'd0);
        check_const("midrst_status", 12'h7C0, 32'd0);
        check("midrst_irq", 64'(ovf_irq), 64'd0);
        #1 cpurst_n = 1'b1;
        tick();
        check_const("post_rst_mcycle", 12'hB00, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
